// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad emulator.
//   state_t          press-sequence states (bounce states only with
//                    KEYPAD_EMU_BOUNCE_EN defined)
//   KEY_ROW_* / KEY_COL_*  bit ranges of the 4-bit key code
//   KEY_IDLE_COL     column pattern with no contact (all released)
//   key_col_pattern  column returns for a key code, contact and row strobes
package keypad_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
`ifdef KEYPAD_EMU_BOUNCE_EN
      ST_BOUNCE_IN,
      ST_BOUNCE_OUT,
`endif
      ST_HOLD,
      ST_GAP
   } state_t;

   localparam int unsigned KEY_ROW_MSB = 3;
   localparam int unsigned KEY_ROW_LSB = 2;
   localparam int unsigned KEY_COL_MSB = 1;
   localparam int unsigned KEY_COL_LSB = 0;

   localparam logic [3:0] KEY_IDLE_COL = 4'b1111;

   // Only the pressed key's row is examined, so several low strobes at once
   // still return a single low column.
   function automatic logic [3:0] key_col_pattern(input logic [3:0] code,
                                                  input logic       contact,
                                                  input logic [3:0] key_row);
      logic [3:0] col;
      col = KEY_IDLE_COL;
      if (contact && !key_row[code[KEY_ROW_MSB:KEY_ROW_LSB]])
         col[code[KEY_COL_MSB:KEY_COL_LSB]] = 1'b0;
      return col;
   endfunction

endpackage

// File: rtl/keypad_emu_timer.sv
// keypad_emu_timer: loadable down-counter shared by all timed states.
//   clock, reset  system clock, asynchronous active-high reset
//   load          load load_val this cycle (takes priority over counting)
//   load_val      initial count (N-1 for an N-cycle state)
//   zero          count has reached zero (state exits on this)
//   tick          (KEYPAD_EMU_BOUNCE_EN only) high every BOUNCE_PERIOD
//                 cycles after a load; drives the bounce toggling
module keypad_emu_timer #(
   parameter int unsigned CNT_W = 4
`ifdef KEYPAD_EMU_BOUNCE_EN
   ,
   parameter int unsigned BOUNCE_PERIOD = 4
`endif
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
`ifdef KEYPAD_EMU_BOUNCE_EN
   ,
   output logic             tick
`endif
);

   logic [CNT_W-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (load)
         count_d = load_val;
      else if (count_q != '0)
         count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign zero = (count_q == '0);

`ifdef KEYPAD_EMU_BOUNCE_EN
   localparam int unsigned PH_W = $clog2(BOUNCE_PERIOD) + 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(BOUNCE_PERIOD - 1);

   logic [PH_W-1:0] phase_d, phase_q;

   // Phase restarts on every load so each bounce window begins with a
   // full BOUNCE_PERIOD of its initial contact level.
   always_comb begin
      phase_d = phase_q - PH_W'(1);
      if (load || phase_q == '0)
         phase_d = PH_LAST;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         phase_q <= '0;
      else
         phase_q <= phase_d;
   end

   assign tick = (phase_q == '0);
`endif

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: answers scanner row strobes with the column returns of a
// commanded key press (hold, release, guard gap).
//   clock, reset      system clock, asynchronous active-high reset
//   req_valid/ready   press request handshake, req_key = {row, col}
//   keyRow            scanner row strobes (active-low)
//   keyCol            registered column returns (active-low, idle 4'b1111)
//   busy              press sequence in progress
//   done              one-cycle pulse on the last GAP cycle
//   cur_key           key code of the active or last press
// Macro KEYPAD_EMU_BOUNCE_EN adds bounce windows before and after the hold.
module keypad_emulator
   import keypad_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES   = 50000,
   parameter int unsigned GAP_CYCLES    = 50000,
   parameter int unsigned BOUNCE_CYCLES = 2000,
   parameter int unsigned BOUNCE_PERIOD = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_valid,
   input  logic [3:0] req_key,
   output logic       req_ready,
   input  logic [3:0] keyRow,
   output logic [3:0] keyCol,
   output logic       busy,
   output logic       done,
   output logic [3:0] cur_key
);

   localparam int unsigned MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int unsigned MAX_CYCLES = (MAX_HG > BOUNCE_CYCLES) ? MAX_HG : BOUNCE_CYCLES;
   localparam int unsigned CNT_W = $clog2(MAX_CYCLES) + 1;

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

   if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || BOUNCE_CYCLES < 1 || BOUNCE_PERIOD < 1) begin : g_bad_params
      $error("keypad_emulator: timing parameters must all be at least 1");
   end

   state_t     state_d, state_q;
   logic [3:0] cur_key_d, cur_key_q;
   logic       contact_d, contact_q;
   logic [3:0] keycol_d, keycol_q;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_load_val;
   logic             tmr_zero;

`ifdef KEYPAD_EMU_BOUNCE_EN
   localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
   logic tmr_tick;

   keypad_emu_timer #(
      .CNT_W         (CNT_W),
      .BOUNCE_PERIOD (BOUNCE_PERIOD)
   ) u_timer (
      .clock    (clock),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .zero     (tmr_zero),
      .tick     (tmr_tick)
   );
`else
   keypad_emu_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clock    (clock),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .zero     (tmr_zero)
   );
`endif

   always_comb begin
      state_d      = state_q;
      cur_key_d    = cur_key_q;
      contact_d    = contact_q;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      req_ready    = 1'b0;
      done         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               cur_key_d = req_key;
               contact_d = 1'b1;
               tmr_load  = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
               state_d      = ST_BOUNCE_IN;
               tmr_load_val = BOUNCE_LOAD;
`else
               state_d      = ST_HOLD;
               tmr_load_val = HOLD_LOAD;
`endif
            end
         end
`ifdef KEYPAD_EMU_BOUNCE_EN
         ST_BOUNCE_IN: begin
            if (tmr_zero) begin
               state_d      = ST_HOLD;
               contact_d    = 1'b1;
               tmr_load     = 1'b1;
               tmr_load_val = HOLD_LOAD;
            end else if (tmr_tick) begin
               contact_d = ~contact_q;
            end
         end
         ST_BOUNCE_OUT: begin
            if (tmr_zero) begin
               state_d      = ST_GAP;
               contact_d    = 1'b0;
               tmr_load     = 1'b1;
               tmr_load_val = GAP_LOAD;
            end else if (tmr_tick) begin
               contact_d = ~contact_q;
            end
         end
`endif
         ST_HOLD: begin
            if (tmr_zero) begin
               contact_d = 1'b0;
               tmr_load  = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
               state_d      = ST_BOUNCE_OUT;
               tmr_load_val = BOUNCE_LOAD;
`else
               state_d      = ST_GAP;
               tmr_load_val = GAP_LOAD;
`endif
            end
         end
         ST_GAP: begin
            if (tmr_zero) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            contact_d = 1'b0;
         end
      endcase
   end

   // Column returns are registered from the contact and strobes of the
   // current cycle, giving the one-cycle response latency.
   always_comb begin
      keycol_d = key_col_pattern(cur_key_q, contact_q, keyRow);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cur_key_q <= 4'h0;
         contact_q <= 1'b0;
         keycol_q  <= KEY_IDLE_COL;
      end else begin
         state_q   <= state_d;
         cur_key_q <= cur_key_d;
         contact_q <= contact_d;
         keycol_q  <= keycol_d;
      end
   end

   assign keyCol  = keycol_q;
   assign cur_key = cur_key_q;
   assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;

   localparam int H = 8;
   localparam int G = 4;
   localparam int B = 6;
   localparam int P = 2;
`ifdef KEYPAD_EMU_BOUNCE_EN
   localparam int OFF = B;
   localparam int TOT = 2*B + H + G;
`else
   localparam int OFF = 0;
   localparam int TOT = H + G;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       req_valid;
   logic [3:0] req_key;
   logic       req_ready;
   logic [3:0] keyRow;
   logic [3:0] keyCol;
   logic       busy;
   logic       done;
   logic [3:0] cur_key;

   int errors = 0;
   int checks = 0;

   // Reference model: m_k = cycles since the accepted request (0 = idle).
   int         m_k;
   logic [3:0] m_key;
   logic [3:0] m_col;
   logic       last_hs;

   keypad_emulator #(
      .HOLD_CYCLES   (H),
      .GAP_CYCLES    (G),
      .BOUNCE_CYCLES (B),
      .BOUNCE_PERIOD (P)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_key   (req_key),
      .req_ready (req_ready),
      .keyRow    (keyRow),
      .keyCol    (keyCol),
      .busy      (busy),
      .done      (done),
      .cur_key   (cur_key)
   );

   always #5 clock = ~clock;

   // Contact level k cycles after the handshake, from the press timeline.
   function automatic logic ref_contact(input int k);
`ifdef KEYPAD_EMU_BOUNCE_EN
      if (k >= 1 && k <= B) return (((k - 1) / P) % 2) == 0;
      if (k > B && k <= B + H) return 1'b1;
      if (k > B + H && k <= 2*B + H) return (((k - B - H - 1) / P) % 2) == 1;
      return 1'b0;
`else
      return (k >= 1 && k <= H);
`endif
   endfunction

   function automatic logic [3:0] ref_col(input logic [3:0] key, input logic c, input logic [3:0] row);
      logic [3:0] col;
      int r;
      int cc;
      col = 4'b1111;
      r = int'(key) / 4;
      cc = int'(key) % 4;
      if (c && row[r] == 1'b0) col[cc] = 1'b0;
      return col;
   endfunction

   // Called at a negedge: drive this cycle's inputs, advance the model to
   // the next cycle, return at the next negedge.
   task automatic step(input logic v, input logic [3:0] key, input logic [3:0] row);
      int k_n;
      logic [3:0] col_n;
      req_valid = v;
      req_key = key;
      keyRow = row;
      last_hs = v && (m_k == 0);
      col_n = ref_col(m_key, ref_contact(m_k), row);
      if (last_hs) k_n = 1;
      else if (m_k == TOT) k_n = 0;
      else if (m_k != 0) k_n = m_k + 1;
      else k_n = 0;
      @(negedge clock);
      if (last_hs) m_key = key;
      m_k = k_n;
      m_col = col_n;
   endtask

   // Step with no request until the model reaches cycle 'target'.
   task automatic run_until(input int target, input logic [3:0] row);
      int n;
      n = 0;
      while (m_k != target && n < 4*TOT) begin
         checks++;
         if (keyCol !== m_col || done !== (m_k == TOT)) begin
            errors++;
            $display("FAIL run k=%0d: keyCol=%b done=%b, expected keyCol=%b done=%b",
                     m_k, keyCol, done, m_col, (m_k == TOT));
         end
         step(1'b0, 4'h0, row);
         n++;
      end
      checks++;
      if (m_k != target) begin
         errors++;
         $display("FAIL run timeout: model k=%0d, expected %0d", m_k, target);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      req_valid = 1'b0;
      req_key = 4'h0;
      keyRow = 4'b1111;
      m_k = 0;
      m_key = 4'h0;
      m_col = 4'b1111;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      keyRow = 4'b1110;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready: got %b need 1", req_ready); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b need 0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b need 0", done); end
      checks++;
      if (cur_key !== 4'h0) begin errors++; $display("FAIL reset cur_key: got %h need 0", cur_key); end
      @(negedge clock);
      repeat (2) step(1'b0, 4'h0, 4'b1110);
      checks++;
      if (keyCol !== 4'b1111) begin errors++; $display("FAIL reset keyCol: got %b need 1111", keyCol); end
   endtask

   task automatic test_press;
      int n;
      int done_at;
      int lows;
      logic [3:0] row;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL press ready: got %b need 1", req_ready); end
      step(1'b1, 4'h6, 4'b1101);
      checks++;
      if (busy !== 1'b1 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL press accept: busy=%b req_ready=%b, need busy=1 req_ready=0", busy, req_ready);
      end
      n = 1;
      done_at = -1;
      lows = 0;
      while (m_k != 0 && n < 4*TOT) begin
         checks++;
         if (keyCol !== m_col) begin
            errors++;
            $display("FAIL press keyCol k=%0d: got %b need %b", m_k, keyCol, m_col);
         end
         if (keyCol === 4'b1011) lows++;
         if (done === 1'b1 && done_at < 0) done_at = n;
         if (m_k == OFF + 3) begin
            checks++;
            if (keyCol !== 4'b1011) begin errors++; $display("FAIL press hold col: got %b need 1011", keyCol); end
         end
         if (m_k == OFF + 6) begin
            checks++;
            if (keyCol !== 4'b1111) begin errors++; $display("FAIL press other row: got %b need 1111", keyCol); end
         end
         row = (m_k == OFF + 4 || m_k == OFF + 5) ? 4'b1110 : 4'b1101;
         step(1'b0, 4'h0, row);
         n++;
      end
      checks++;
      if (done_at != TOT) begin errors++; $display("FAIL press done cycle: got %0d need %0d", done_at, TOT); end
      checks++;
`ifdef KEYPAD_EMU_BOUNCE_EN
      if (lows != 12) begin errors++; $display("FAIL press low cycles: got %0d need 12", lows); end
`else
      if (lows != 6) begin errors++; $display("FAIL press low cycles: got %0d need 6", lows); end
`endif
   endtask

   task automatic test_contact_window;
      int lows;
      int done_at;
      int n;
      step(1'b1, 4'h0, 4'b1110);
      lows = 0;
      done_at = -1;
      n = 1;
      while (m_k != 0 && n < 4*TOT) begin
         checks++;
         if (keyCol !== m_col) begin
            errors++;
            $display("FAIL window keyCol k=%0d: got %b need %b", m_k, keyCol, m_col);
         end
         if (keyCol[0] === 1'b0) lows++;
         if (done === 1'b1 && done_at < 0) done_at = n;
         step(1'b0, 4'h0, 4'b1110);
         n++;
      end
      checks++;
`ifdef KEYPAD_EMU_BOUNCE_EN
      if (lows != 14 || done_at != 24) begin
         errors++;
         $display("FAIL window: lows=%0d done_at=%0d, need lows=14 done_at=24", lows, done_at);
      end
`else
      if (lows != 8 || done_at != 12) begin
         errors++;
         $display("FAIL window: lows=%0d done_at=%0d, need lows=8 done_at=12", lows, done_at);
      end
`endif
   endtask

   task automatic test_back_to_back;
      int n;
      int done_n;
      int acc_n;
      step(1'b1, 4'h3, 4'b0111);
      n = 0;
      done_n = -1;
      acc_n = -1;
      while (acc_n < 0 && n < 4*TOT) begin
         checks++;
         if (req_ready !== (m_k == 0) || busy !== (m_k != 0)) begin
            errors++;
            $display("FAIL b2b k=%0d: req_ready=%b busy=%b, need req_ready=%b busy=%b",
                     m_k, req_ready, busy, (m_k == 0), (m_k != 0));
         end
         checks++;
         if (done === 1'b1 && req_ready === 1'b1) begin
            errors++;
            $display("FAIL b2b overlap: done=1 req_ready=1, need not both");
         end
         if (done === 1'b1) done_n = n;
         step(1'b1, 4'hF, 4'b0111);
         if (last_hs) acc_n = n;
         n++;
      end
      checks++;
      if (acc_n != done_n + 1 || done_n != TOT - 1) begin
         errors++;
         $display("FAIL b2b accept: accepted at %0d done at %0d, need done at %0d then accept next", acc_n, done_n, TOT - 1);
      end
      checks++;
      if (cur_key !== 4'hF) begin errors++; $display("FAIL b2b cur_key: got %h need f", cur_key); end
      run_until(OFF + 3, 4'b0111);
      checks++;
      if (keyCol !== 4'b0111) begin errors++; $display("FAIL b2b keyCol: got %b need 0111", keyCol); end
      run_until(0, 4'b0111);
   endtask

   task automatic test_reset_mid;
      step(1'b1, 4'h5, 4'b1101);
      run_until(OFF + 3, 4'b1101);
      checks++;
      if (keyCol !== 4'b1101) begin errors++; $display("FAIL midrst pre: got %b need 1101", keyCol); end
      reset = 1'b1;
      #1;
      checks++;
      if (keyCol !== 4'b1111 || busy !== 1'b0 || cur_key !== 4'h0) begin
         errors++;
         $display("FAIL midrst: keyCol=%b busy=%b cur_key=%h, need 1111 0 0", keyCol, busy, cur_key);
      end
      @(negedge clock);
      reset = 1'b0;
      m_k = 0;
      m_key = 4'h0;
      m_col = 4'b1111;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst ready: got %b need 1", req_ready); end
      @(negedge clock);
      step(1'b1, 4'hA, 4'b1011);
      checks++;
      if (busy !== 1'b1 || cur_key !== 4'hA) begin
         errors++;
         $display("FAIL midrst new press: busy=%b cur_key=%h, need 1 a", busy, cur_key);
      end
      run_until(0, 4'b1011);
   endtask

   task automatic test_multi_row;
      step(1'b1, 4'h9, 4'b0000);
      run_until(OFF + 3, 4'b0000);
      checks++;
      if (keyCol !== 4'b1101) begin errors++; $display("FAIL multirow: got %b need 1101", keyCol); end
      run_until(0, 4'b0000);
      step(1'b1, 4'h9, 4'b1111);
      run_until(OFF + 3, 4'b1111);
      checks++;
      if (keyCol !== 4'b1111) begin errors++; $display("FAIL norow: got %b need 1111", keyCol); end
      run_until(0, 4'b1111);
   endtask

   task automatic test_random;
      logic v;
      logic [3:0] key;
      logic [3:0] row;
      for (int i = 0; i < 400; i++) begin
         checks++;
         if (keyCol !== m_col || busy !== (m_k != 0) || req_ready !== (m_k == 0) ||
             done !== (m_k == TOT) || cur_key !== m_key) begin
            errors++;
            $display("FAIL random i=%0d: col=%b busy=%b rdy=%b done=%b key=%h, need col=%b busy=%b rdy=%b done=%b key=%h",
                     i, keyCol, busy, req_ready, done, cur_key,
                     m_col, (m_k != 0), (m_k == 0), (m_k == TOT), m_key);
         end
         v = ($urandom_range(0, 3) == 0);
         key = 4'($urandom);
         row = 4'($urandom);
         step(v, key, row);
      end
   endtask

   initial begin
      test_reset;
      test_press;
      test_contact_window;
      test_back_to_back;
      test_reset_mid;
      test_multi_row;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
